// File: rtl/apb_gpio_pkg.sv
// APB GPIO slave shared definitions.
// Register offsets, ID constant and FSM state encoding.
package apb_gpio_pkg;

    localparam logic [7:0] ADDR_LED     = 8'h00;
    localparam logic [7:0] ADDR_SWITCH  = 8'h04;
    localparam logic [7:0] ADDR_SCRATCH = 8'h08;
    localparam logic [7:0] ADDR_ID      = 8'h0C;

    localparam logic [31:0] GPIO_ID = 32'h4750_4F31;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/apb_gpio_slave_if.sv
// APB completer bus bundle.
// Master drives the request, slave drives the response.
interface apb_gpio_slave_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0] pADDR;
    logic          pSELx;
    logic          pENABLE;
    logic          pWRITE;
    logic [DW-1:0] pWDATA;
    logic [DW-1:0] pRDATA;
    logic          pREADY;
    logic          pSLVERR;

    modport master (
        output pADDR, pSELx, pENABLE, pWRITE, pWDATA,
        input  pRDATA, pREADY, pSLVERR
    );

    modport slave (
        input  pADDR, pSELx, pENABLE, pWRITE, pWDATA,
        output pRDATA, pREADY, pSLVERR
    );
endinterface

// File: rtl/apb_gpio_slave_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Output lags the input by two clock edges.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Shift the input through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/apb_gpio_slave.sv
// APB GPIO completer: LED, switch, scratch and ID registers.
// Fixed wait-state count, registered pREADY/pSLVERR/pRDATA.
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic               pCLK,
    input  logic               pRESETn,
    apb_gpio_slave_if.slave    bus,
    input  logic [15:0]        switch,
    output logic [15:0]        led
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic [15:0]   led_q;
    logic [DW-1:0] scratch_q;
    logic [15:0]   sw_sync;
    logic          ready_q;
    logic          slverr_q;
    logic [DW-1:0] rdata_q;
    logic          addr_err;
    logic          wr_en;
    logic [DW-1:0] rd_mux;

    sync_2ff #(
        .W (16)
    ) u_sync (
        .clk   (pCLK),
        .rst_n (pRESETn),
        .d     (switch),
        .q     (sw_sync)
    );

    assign addr_err = (bus.pADDR > AW'(ADDR_ID))
                   || (bus.pADDR[1:0] != 2'b00);

    assign wr_en = (state_q == ST_DONE) && bus.pSELx
                && bus.pENABLE && bus.pWRITE && !addr_err;

    // Select the addressed register for a read.
    always_comb begin
        rd_mux = '0;
        if (!addr_err) begin
            case (bus.pADDR[3:2])
                2'd0:    rd_mux = DW'(led_q);
                2'd1:    rd_mux = DW'(sw_sync);
                2'd2:    rd_mux = scratch_q;
                default: rd_mux = DW'(GPIO_ID);
            endcase
        end
    end

    // Next-state logic: setup -> wait count -> done -> idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.pSELx && !bus.pENABLE) begin
                    if (WS == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.pSELx) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and response registers track the next state.
    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= (state_d == ST_DONE);
            slverr_q <= (state_d == ST_DONE) && addr_err;
            if ((state_d == ST_DONE) && !bus.pWRITE && !addr_err) begin
                rdata_q <= rd_mux;
            end else begin
                rdata_q <= '0;
            end
        end
    end

    // Commit writes to the RW registers in the completing cycle.
    always_ff @(posedge pCLK or negedge pRESETn) begin
        if (!pRESETn) begin
            led_q     <= 16'h0;
            scratch_q <= '0;
        end else if (wr_en) begin
            if (bus.pADDR == AW'(ADDR_LED)) begin
                led_q <= bus.pWDATA[15:0];
            end
            if (bus.pADDR == AW'(ADDR_SCRATCH)) begin
                scratch_q <= bus.pWDATA;
            end
        end
    end

    assign bus.pREADY  = ready_q;
    assign bus.pSLVERR = slverr_q;
    assign bus.pRDATA  = rdata_q;
    assign led         = led_q;
endmodule

// File: tb/tb_apb_gpio_slave.sv
// Bench for apb_gpio_slave: one DUT with one wait state, one with none.
// Directed steps followed by random transfers against a register model.
module tb_apb_gpio_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = 16'h0;
    logic [15:0] led1;
    logic [15:0] led0;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_led [2];
    logic [31:0] m_scr [2];
    logic [15:0] m_sw;

    always #5 clk = ~clk;

    apb_gpio_slave_if #(.DW(32), .AW(32)) bus1 ();
    apb_gpio_slave_if #(.DW(32), .AW(32)) bus0 ();

    apb_gpio_slave #(
        .DW (32), .AW (32), .WAIT_STATES (1)
    ) dut1 (
        .pCLK (clk), .pRESETn (rst_n), .bus (bus1),
        .switch (sw), .led (led1)
    );

    apb_gpio_slave #(
        .DW (32), .AW (32), .WAIT_STATES (0)
    ) dut0 (
        .pCLK (clk), .pRESETn (rst_n), .bus (bus0),
        .switch (sw), .led (led0)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a > 32'd12) || (a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input int d,
                                               input logic [31:0] a);
        case (a)
            32'h0:   return {16'h0, m_led[d]};
            32'h4:   return {16'h0, m_sw};
            32'h8:   return m_scr[d];
            32'hC:   return 32'h4750_4F31;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [15:0] led_of(input int d);
        return (d == 1) ? led1 : led0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_led[i] = 16'h0;
            m_scr[i] = 32'h0;
        end
    endtask

    task automatic drive(input int d, input logic sel, input logic en,
                         input logic [31:0] a, input logic w,
                         input logic [31:0] wd);
        if (d == 1) begin
            bus1.pSELx = sel; bus1.pENABLE = en;
            bus1.pADDR = a;   bus1.pWRITE = w; bus1.pWDATA = wd;
        end else begin
            bus0.pSELx = sel; bus0.pENABLE = en;
            bus0.pADDR = a;   bus0.pWRITE = w; bus0.pWDATA = wd;
        end
    endtask

    task automatic sample(input int d, output logic rdy,
                          output logic [31:0] rd, output logic err);
        if (d == 1) begin
            rdy = bus1.pREADY; rd = bus1.pRDATA; err = bus1.pSLVERR;
        end else begin
            rdy = bus0.pREADY; rd = bus0.pRDATA; err = bus0.pSLVERR;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [15:0] v);
        sw = v;
        m_sw = v;
        idle(3);
    endtask

    // Entered and left just after a rising edge.
    task automatic xfer(input int d, input logic [31:0] a,
                        input logic w, input logic [31:0] wd);
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic        err;
        logic        exp_err;
        logic        rdy;
        int          n;
        exp_err = is_err(a);
        exp_rd  = (w || exp_err) ? 32'h0 : model_read(d, a);
        drive(d, 1'b1, 1'b0, a, w, wd);
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, a, w, wd);
        n = 0;
        rdy = 1'b0;
        rd = 32'h0;
        err = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
            sample(d, rdy, rd, err);
            if (!rdy) begin
                chk("rdata_while_waiting", rd, 32'h0);
                chk("slverr_while_waiting", {31'h0, err}, 32'h0);
            end
        end
        chk("ready_access_cycle", 32'(n), 32'(d + 1));
        chk("rdata", rd, exp_rd);
        chk("slverr", {31'h0, err}, {31'h0, exp_err});
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, a, w, wd);
        if (w && !exp_err) begin
            if (a == 32'h0) m_led[d] = wd[15:0];
            if (a == 32'h8) m_scr[d] = wd;
        end
        chk("led_after", {16'h0, led_of(d)}, {16'h0, m_led[d]});
    endtask

    initial begin
        logic        rdy;
        logic [31:0] rd;
        logic        err;
        logic [31:0] a;
        int          d;
        int          r;

        drive(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();
        m_sw = 16'h0;
        #12;
        for (int i = 0; i < 2; i++) begin
            sample(i, rdy, rd, err);
            chk("reset_ready", {31'h0, rdy}, 32'h0);
            chk("reset_slverr", {31'h0, err}, 32'h0);
            chk("reset_rdata", rd, 32'h0);
            chk("reset_led", {16'h0, led_of(i)}, 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        xfer(1, 32'h0, 1'b1, 32'h0000_A5A5);
        chk("led_a5a5", {16'h0, led1}, 32'h0000_A5A5);
        xfer(1, 32'h0, 1'b0, 32'h0);
        xfer(1, 32'h8, 1'b1, 32'hDEAD_BEEF);
        xfer(1, 32'h8, 1'b0, 32'h0);
        xfer(1, 32'hC, 1'b0, 32'h0);

        set_sw(16'h1234);
        xfer(1, 32'h4, 1'b0, 32'h0);
        xfer(1, 32'h4, 1'b1, 32'hFFFF_FFFF);
        xfer(1, 32'h4, 1'b0, 32'h0);

        xfer(1, 32'h20, 1'b0, 32'h0);
        xfer(1, 32'h6, 1'b1, 32'h0000_5A5A);
        xfer(1, 32'h0, 1'b0, 32'h0);
        xfer(1, 32'h8, 1'b0, 32'h0);

        xfer(0, 32'h8, 1'b1, 32'h1234_5678);
        xfer(0, 32'h8, 1'b0, 32'h0);
        xfer(0, 32'h4, 1'b0, 32'h0);

        // Master abandons a write in the wait cycle.
        drive(1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_BEEF);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0000_BEEF);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_ready", {31'h0, bus1.pREADY}, 32'h0);
        end
        @(posedge clk); #1;
        chk("abort_led", {16'h0, led1}, {16'h0, m_led[1]});
        xfer(1, 32'h0, 1'b0, 32'h0);

        // Reset arrives while a write is waiting.
        drive(1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_FFFF);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h0, 1'b1, 32'h0000_FFFF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_ready", {31'h0, bus1.pREADY}, 32'h0);
        chk("rst_mid_led", {16'h0, led1}, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_hold_ready", {31'h0, bus1.pREADY}, 32'h0);
        chk("rst_hold_led", {16'h0, led1}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1, 32'h0, 1'b1, 32'h0000_0001);
        xfer(1, 32'h8, 1'b0, 32'h0);
        xfer(0, 32'h8, 1'b0, 32'h0);

        for (int it = 0; it < 60; it++) begin
            if (it % 10 == 0) set_sw(16'($urandom));
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            if (r < 4) begin
                a = 32'(r * 4);
            end else if (r == 4) begin
                a = 32'(4 * $urandom_range(4, 16));
            end else if (r == 5) begin
                a = $urandom;
                a[1:0] = 2'($urandom_range(1, 3));
            end else begin
                a = (r == 6) ? 32'h0 : 32'h8;
            end
            xfer(d, a, 1'($urandom_range(0, 1)), $urandom);
            idle(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
